// File: rtl/pair_dist_gen.sv
// pair_dist_gen: buffers NUM_POINTS 3-D points, then enumerates every unordered pair (i < j)
// at one pair per cycle, emitting {squared distance, i, j} tuples for the insertion sorter.
//
// Optional feature macro: PAIR_GEN_BACKPRESSURE_EN (adds conn_out_rdy; pipeline stalls on it).
//
// Ports:
//   clk           in   system clock
//   rst_n         in   synchronous active-low reset
//   pt_x/y/z      in   point coordinates, DIM_W bits each (unsigned)
//   pt_vld        in   point write strobe, honoured only while loading
//   clear         in   abort/restart, returns to loading with empty pipeline
//   conn_out_rdy  in   downstream ready (only with PAIR_GEN_BACKPRESSURE_EN)
//   conn_out      out  {dist[2*DIM_W+1:0], pointa[IDX_W-1:0], pointb[IDX_W-1:0]}
//   conn_out_vld  out  one cycle per tuple (held while stalled)
//   done          out  all pairs emitted and pipeline empty
//
// Pair issue to conn_out_vld is a fixed 3-cycle latency (read, abs-diff, square+sum).
module pair_dist_gen #(
  parameter int unsigned NUM_POINTS = 1000,
  parameter int unsigned DIM_W      = 17,
  localparam int unsigned IDX_W     = $clog2(NUM_POINTS),
  localparam int unsigned DIST_W    = 2 * DIM_W + 2,
  localparam int unsigned CONN_W    = DIST_W + 2 * IDX_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DIM_W-1:0]  pt_x,
  input  logic [DIM_W-1:0]  pt_y,
  input  logic [DIM_W-1:0]  pt_z,
  input  logic              pt_vld,
  input  logic              clear,
`ifdef PAIR_GEN_BACKPRESSURE_EN
  input  logic              conn_out_rdy,
`endif
  output logic [CONN_W-1:0] conn_out,
  output logic              conn_out_vld,
  output logic              done
);

  typedef enum logic [1:0] {StLoad, StGen, StDrain, StDone} state_e;

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_POINTS - 1);
  localparam logic [IDX_W-1:0] PenIdx  = IDX_W'(NUM_POINTS - 2);

  state_e state_q, state_d;

  logic [3*DIM_W-1:0] mem [NUM_POINTS];
  logic [IDX_W-1:0]   wr_ptr_q, i_q, j_q;
  logic               adv, issue, last_pair, wr_en;

  logic               s1_vld_q, s2_vld_q, conn_vld_q;
  logic [3*DIM_W-1:0] s1_a_q, s1_b_q;
  logic [IDX_W-1:0]   s1_ia_q, s1_ib_q, s2_ia_q, s2_ib_q;
  logic [DIM_W-1:0]   s2_dx_q, s2_dy_q, s2_dz_q;
  logic [CONN_W-1:0]  conn_q;
  logic [DIST_W-1:0]  dist_sum;

  // Single advance enable: the whole pipeline and pair counter move together.
`ifdef PAIR_GEN_BACKPRESSURE_EN
  assign adv = !conn_vld_q || conn_out_rdy;
`else
  assign adv = 1'b1;
`endif

  assign wr_en     = (state_q == StLoad) && pt_vld && !clear;
  assign issue     = (state_q == StGen) && adv;
  assign last_pair = (i_q == PenIdx) && (j_q == LastIdx);

  function automatic logic [DIM_W-1:0] abs_diff(input logic [DIM_W-1:0] a,
                                                input logic [DIM_W-1:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

  function automatic logic [2*DIM_W-1:0] square(input logic [DIM_W-1:0] v);
    logic [2*DIM_W-1:0] w;
    w = {{DIM_W{1'b0}}, v};
    return w * w;
  endfunction

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StLoad;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = StLoad;
    end else begin
      unique case (state_q)
        StLoad:  if (wr_en && (wr_ptr_q == LastIdx)) state_d = StGen;
        StGen:   if (issue && last_pair) state_d = StDrain;
        // The output stage must be empty or handing off its tuple this cycle.
        StDrain: if (!s1_vld_q && !s2_vld_q && (!conn_vld_q || adv)) state_d = StDone;
        StDone:  state_d = StDone;
        default: state_d = StLoad;
      endcase
    end
  end

  // FSM outputs
  always_comb begin
    done         = (state_q == StDone);
    conn_out     = conn_q;
    conn_out_vld = conn_vld_q;
  end

  // Write pointer and pair enumeration counters
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      wr_ptr_q <= '0;
      i_q      <= '0;
      j_q      <= IDX_W'(1);
    end else begin
      if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + IDX_W'(1);
      end
      if (issue && !last_pair) begin
        if (j_q == LastIdx) begin
          i_q <= i_q + IDX_W'(1);
          j_q <= i_q + IDX_W'(2);
        end else begin
          j_q <= j_q + IDX_W'(1);
        end
      end
    end
  end

  // Point storage, intentionally not reset
  always_ff @(posedge clk) begin
    if (rst_n && wr_en) begin
      mem[wr_ptr_q] <= {pt_x, pt_y, pt_z};
    end
  end

  // Pipeline valids
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      s1_vld_q   <= 1'b0;
      s2_vld_q   <= 1'b0;
      conn_vld_q <= 1'b0;
    end else if (adv) begin
      s1_vld_q   <= issue;
      s2_vld_q   <= s1_vld_q;
      conn_vld_q <= s2_vld_q;
    end
  end

  // S1: point read, S2: per-axis absolute difference
  always_ff @(posedge clk) begin
    if (adv) begin
      if (issue) begin
        s1_a_q  <= mem[i_q];
        s1_b_q  <= mem[j_q];
        s1_ia_q <= i_q;
        s1_ib_q <= j_q;
      end
      if (s1_vld_q) begin
        s2_dx_q <= abs_diff(s1_a_q[3*DIM_W-1:2*DIM_W], s1_b_q[3*DIM_W-1:2*DIM_W]);
        s2_dy_q <= abs_diff(s1_a_q[2*DIM_W-1:DIM_W],   s1_b_q[2*DIM_W-1:DIM_W]);
        s2_dz_q <= abs_diff(s1_a_q[DIM_W-1:0],         s1_b_q[DIM_W-1:0]);
        s2_ia_q <= s1_ia_q;
        s2_ib_q <= s1_ib_q;
      end
    end
  end

  // S3: two guard bits make the three-term sum overflow-free
  always_comb begin
    dist_sum = DIST_W'(square(s2_dx_q)) + DIST_W'(square(s2_dy_q)) + DIST_W'(square(s2_dz_q));
  end

  // conn_out holds its last tuple whenever nothing new arrives; clear leaves it untouched.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      conn_q <= '0;
    end else if (!clear && adv && s2_vld_q) begin
      conn_q <= {dist_sum, s2_ia_q, s2_ib_q};
    end
  end

endmodule

// File: tb/tb_pair_dist_gen.sv
// tb_pair_dist_gen: randomized and directed self-checking bench for pair_dist_gen.
// Instance u_dut_a uses NUM_POINTS=4, u_dut_b uses NUM_POINTS=2; expected tuples come from a
// nested-loop distance model. Honours PAIR_GEN_BACKPRESSURE_EN when defined.
module tb_pair_dist_gen;

  localparam int unsigned DIM_W = 17;
  localparam int unsigned NA    = 4;
  localparam int unsigned CWA   = 2 * DIM_W + 2 + 2 * 2;
  localparam int unsigned CWB   = 2 * DIM_W + 2 + 2 * 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic [DIM_W-1:0] a_x, a_y, a_z, b_x, b_y, b_z;
  logic             a_vld, a_clr, a_rdy, b_vld, b_clr, b_rdy;
  logic [CWA-1:0]   a_conn;
  logic [CWB-1:0]   b_conn;
  logic             a_cvld, a_done, b_cvld, b_done;

  pair_dist_gen #(.NUM_POINTS(NA), .DIM_W(DIM_W)) u_dut_a (
    .clk          (clk),
    .rst_n        (rst_n),
    .pt_x         (a_x),
    .pt_y         (a_y),
    .pt_z         (a_z),
    .pt_vld       (a_vld),
    .clear        (a_clr),
`ifdef PAIR_GEN_BACKPRESSURE_EN
    .conn_out_rdy (a_rdy),
`endif
    .conn_out     (a_conn),
    .conn_out_vld (a_cvld),
    .done         (a_done)
  );

  pair_dist_gen #(.NUM_POINTS(2), .DIM_W(DIM_W)) u_dut_b (
    .clk          (clk),
    .rst_n        (rst_n),
    .pt_x         (b_x),
    .pt_y         (b_y),
    .pt_z         (b_z),
    .pt_vld       (b_vld),
    .clear        (b_clr),
`ifdef PAIR_GEN_BACKPRESSURE_EN
    .conn_out_rdy (b_rdy),
`endif
    .conn_out     (b_conn),
    .conn_out_vld (b_cvld),
    .done         (b_done)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [DIM_W-1:0] px [NA];
  logic [DIM_W-1:0] py [NA];
  logic [DIM_W-1:0] pz [NA];
  logic [63:0]      exp_q [$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic longint unsigned sq_dist(input logic [DIM_W-1:0] x0, input logic [DIM_W-1:0] y0,
                                              input logic [DIM_W-1:0] z0, input logic [DIM_W-1:0] x1,
                                              input logic [DIM_W-1:0] y1, input logic [DIM_W-1:0] z1);
    longint dx, dy, dz;
    dx = longint'(x0) - longint'(x1);
    dy = longint'(y0) - longint'(y1);
    dz = longint'(z0) - longint'(z1);
    return longint'(dx * dx + dy * dy + dz * dz);
  endfunction

  // Reference: every pair i<j in lexicographic order, packed as {dist, i, j}
  function automatic void build_exp();
    exp_q.delete();
    for (int i = 0; i < NA; i++) begin
      for (int j = i + 1; j < NA; j++) begin
        exp_q.push_back((64'(sq_dist(px[i], py[i], pz[i], px[j], py[j], pz[j])) << 4)
                        | (64'(i) << 2) | 64'(j));
      end
    end
  endfunction

  task automatic set_s1();
    px[0] = 0; py[0] = 0; pz[0] = 0;
    px[1] = 1; py[1] = 2; pz[1] = 2;
    px[2] = 3; py[2] = 0; pz[2] = 4;
    px[3] = 0; py[3] = 0; pz[3] = 0;
  endtask

  task automatic load_a(input int cnt);
    for (int p = 0; p < cnt; p++) begin
      a_x = px[p]; a_y = py[p]; a_z = pz[p]; a_vld = 1'b1;
      tick();
    end
    a_vld = 1'b0;
  endtask

  task automatic junk_a();
    a_vld = 1'b1;
    a_x = DIM_W'($urandom); a_y = DIM_W'($urandom); a_z = DIM_W'($urandom);
  endtask

  task automatic clear_a(input string tag);
    a_clr = 1'b1;
    tick();
    a_clr = 1'b0;
    check_eq({tag, " clr vld"}, 64'(a_cvld), 64'd0);
    check_eq({tag, " clr done"}, 64'(a_done), 64'd0);
  endtask

  // Runs dut A after a complete load; clear_at>0 aborts once that many tuples were taken.
  task automatic collect_a(input string tag, input bit junk, input int clear_at);
    logic [63:0]    got_q [$];
    logic [CWA-1:0] prev_conn;
    bit             prev_stall, cleared;
    int             first_c, last_c, done_c, clear_c, drops, late_vld;
    prev_stall = 1'b0; cleared = 1'b0; prev_conn = '0;
    first_c = -1; last_c = -1; done_c = -1; clear_c = -1; drops = 0; late_vld = 0;
    build_exp();
    if (junk) junk_a();
    for (int c = 1; c <= 80; c++) begin
      tick();
`ifdef PAIR_GEN_BACKPRESSURE_EN
      a_rdy = (c % 3 == 1);
`endif
      if (junk) junk_a();
      if (prev_stall) begin
        check_eq($sformatf("%s stall hold c%0d", tag, c), 64'(a_conn), 64'(prev_conn));
        check_eq($sformatf("%s stall vld c%0d", tag, c), 64'(a_cvld), 64'd1);
      end
      if (a_cvld && first_c < 0) first_c = c;
      if (cleared && a_cvld) late_vld++;
      if (a_cvld && a_rdy && !cleared) begin
        got_q.push_back(64'(a_conn));
        last_c = c;
      end
      prev_stall = a_cvld && !a_rdy;
      prev_conn  = a_conn;
      if (a_done && done_c < 0) done_c = c;
      if (done_c >= 0 && !a_done) drops++;
      if (clear_at > 0 && !cleared && got_q.size() == clear_at) begin
        a_clr = 1'b1;
        tick();
        a_clr = 1'b0;
        check_eq({tag, " vld after clear"}, 64'(a_cvld), 64'd0);
        cleared    = 1'b1;
        clear_c    = c;
        prev_stall = 1'b0;
      end
      if (done_c >= 0 && c >= done_c + 5) break;
      if (cleared && c >= clear_c + 12) break;
    end
    a_vld = 1'b0;
    check_eq({tag, " first vld latency"}, 64'(first_c), 64'd3);
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
      check_eq($sformatf("%s tuple%0d", tag, k), got_q[k], exp_q[k]);
    end
    if (cleared) begin
      check_eq({tag, " tuples before clear"}, 64'(got_q.size()), 64'(clear_at));
      check_eq({tag, " vld after clear cnt"}, 64'(late_vld), 64'd0);
      check_eq({tag, " no done"}, 64'(done_c), 64'hffff_ffff_ffff_ffff);
    end else begin
      check_eq({tag, " tuple count"}, 64'(got_q.size()), 64'(exp_q.size()));
      check_eq({tag, " done timing"}, 64'(done_c), 64'(last_c + 1));
      check_eq({tag, " done held"}, 64'(drops), 64'd0);
      check_eq({tag, " vld in done"}, 64'(a_cvld), 64'd0);
    end
  endtask

  task automatic run_b(input string tag, input logic [DIM_W-1:0] x0, input logic [DIM_W-1:0] y0,
                       input logic [DIM_W-1:0] z0, input logic [DIM_W-1:0] x1,
                       input logic [DIM_W-1:0] y1, input logic [DIM_W-1:0] z1,
                       input logic [63:0] exp_dist);
    int          n;
    logic [63:0] got;
    n = 0; got = '0;
    b_x = x0; b_y = y0; b_z = z0; b_vld = 1'b1; tick();
    b_x = x1; b_y = y1; b_z = z1; tick();
    b_vld = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (b_cvld) begin
        n++;
        got = 64'(b_conn);
      end
    end
    check_eq({tag, " count"}, 64'(n), 64'd1);
    check_eq({tag, " tuple"}, got, (exp_dist << 2) | 64'd1);
    check_eq({tag, " model dist"}, 64'(sq_dist(x0, y0, z0, x1, y1, z1)), exp_dist);
    check_eq({tag, " done"}, 64'(b_done), 64'd1);
    b_clr = 1'b1; tick(); b_clr = 1'b0;
    check_eq({tag, " clr done"}, 64'(b_done), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    a_x = '0; a_y = '0; a_z = '0; a_vld = 1'b0; a_clr = 1'b0; a_rdy = 1'b1;
    b_x = '0; b_y = '0; b_z = '0; b_vld = 1'b0; b_clr = 1'b0; b_rdy = 1'b1;
    tick(); tick();
    check_eq("reset conn_a", 64'(a_conn), 64'd0);
    check_eq("reset vld_a", 64'(a_cvld), 64'd0);
    check_eq("reset done_a", 64'(a_done), 64'd0);
    check_eq("reset conn_b", 64'(b_conn), 64'd0);
    rst_n = 1'b1;
    tick();

    // Directed set, then junk writes during GEN/DONE
    set_s1();
    load_a(NA); collect_a("s1", 1'b0, 0); clear_a("s1");
    load_a(NA); collect_a("s3", 1'b1, 0); clear_a("s3");

    // Clear on the second tuple, then a full reload
    load_a(NA); collect_a("s4", 1'b0, 2);
    load_a(NA); collect_a("s4 reload", 1'b0, 0); clear_a("s4");

    // Reset after a partial load
    load_a(2);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    check_eq("s5 reset conn", 64'(a_conn), 64'd0);
    check_eq("s5 reset vld", 64'(a_cvld), 64'd0);
    check_eq("s5 reset done", 64'(a_done), 64'd0);
    load_a(NA); collect_a("s5", 1'b0, 0); clear_a("s5");

    // Random sets with occasional full-scale and duplicate points
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < NA; k++) begin
        case ($urandom_range(0, 3))
          0: begin px[k] = '1; py[k] = '1; pz[k] = '1; end
          1: if (k > 0) begin
               px[k] = px[k-1]; py[k] = py[k-1]; pz[k] = pz[k-1];
             end else begin
               px[k] = '0; py[k] = '0; pz[k] = '0;
             end
          default: begin
            px[k] = DIM_W'($urandom); py[k] = DIM_W'($urandom); pz[k] = DIM_W'($urandom);
          end
        endcase
      end
      load_a(NA);
      collect_a($sformatf("rand%0d", r), r[0], 0);
      clear_a($sformatf("rand%0d", r));
    end

    // Two-point instance at full scale, both load orders
    run_b("s2 fwd", '1, '1, '1, '0, '0, '0, 64'd51538821123);
    run_b("s2 swap", '0, '0, '0, '1, '1, '1, 64'd51538821123);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
